beta_serial: RTL and testbench

- Iterative, parametrised beta (S-box column) layer for the SWAN datapath.
- Applies a 4-bit S-box to each bit-sliced column of one half-state, LANES columns per clock; reuses S-box instances across cycles, trading latency for area.
- Adds an inverse mode (decryption), valid/ready handshakes on both sides, and a synchronous abort.
- Sits between the round-function mixing stage and the round register controller.

---
 rtl/beta_serial.sv | 179 +++++++++++++++++
 tb/tb_beta_serial.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_serial.sv
// Iterative SWAN beta layer: a 4-bit S-box applied to every bit-sliced column of a half-state.
// LANES forward and LANES inverse S-boxes are reused across COLUMN_SIZE/LANES cycles.

module sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        // NOTE: the default arm assigns y on every path, so no latch can be inferred.
        case (x)
            4'h0: y = 4'h1;
            4'h1: y = 4'h2;
            4'h2: y = 4'hC;
            4'h3: y = 4'h5;
            4'h4: y = 4'h7;
            4'h5: y = 4'h8;
            4'h6: y = 4'hA;
            4'h7: y = 4'hF;
            4'h8: y = 4'h4;
            4'h9: y = 4'hD;
            4'hA: y = 4'hB;
            4'hB: y = 4'hE;
            4'hC: y = 4'h9;
            4'hD: y = 4'h6;
            4'hE: y = 4'h0;
            default: y = 4'h3;
        endcase
    end
endmodule

module sbox_inv (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        case (x)
            4'h0: y = 4'hE;
            4'h1: y = 4'h0;
            4'h2: y = 4'h1;
            4'h3: y = 4'hF;
            4'h4: y = 4'h8;
            4'h5: y = 4'h3;
            4'h6: y = 4'hD;
            4'h7: y = 4'h4;
            4'h8: y = 4'h5;
            4'h9: y = 4'hC;
            4'hA: y = 4'h6;
            4'hB: y = 4'hA;
            4'hC: y = 4'h2;
            4'hD: y = 4'h9;
            4'hE: y = 4'hB;
            default: y = 4'h7;
        endcase
    end
endmodule

module beta_serial #(
    parameter int SIDE_SIZE   = 64,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int LANES       = 4,
    parameter int CNT_W       = ((COLUMN_SIZE / LANES) > 1) ? $clog2(COLUMN_SIZE / LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inv,
    input  logic [0:SIDE_SIZE-1] x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:SIDE_SIZE-1] y,
    output logic                 busy
);
    localparam int               ITERS = COLUMN_SIZE / LANES;
    localparam int               COL_W = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITERS - 1);

    if (SIDE_SIZE % 4 != 0) begin : g_bad_side
        $error("beta_serial: SIDE_SIZE must be a multiple of 4");
    end
    if (COLUMN_SIZE != SIDE_SIZE / 4) begin : g_bad_column
        $error("beta_serial: COLUMN_SIZE is derived and must not be overridden");
    end
    if (LANES < 1 || COLUMN_SIZE % LANES != 0) begin : g_bad_lanes
        $error("beta_serial: COLUMN_SIZE must be a non-zero multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mode;
    logic [3:0]       x_col   [COLUMN_SIZE];
    logic [3:0]       src_col [COLUMN_SIZE];
    logic [3:0]       res_col [COLUMN_SIZE];
    logic [COL_W-1:0] lane_col [LANES];
    logic [3:0]       lane_in  [LANES];
    logic [3:0]       lane_fwd [LANES];
    logic [3:0]       lane_bwd [LANES];
    logic [3:0]       lane_out [LANES];

    // Column j gathers one bit from each quarter of the half-state, x[j] as nibble MSB.
    for (genvar j = 0; j < COLUMN_SIZE; j++) begin : g_col
        assign x_col[j] = {x[j], x[j+COLUMN_SIZE], x[j+2*COLUMN_SIZE], x[j+3*COLUMN_SIZE]};
        assign y[j]                 = res_col[j][3];
        assign y[j+COLUMN_SIZE]     = res_col[j][2];
        assign y[j+2*COLUMN_SIZE]   = res_col[j][1];
        assign y[j+3*COLUMN_SIZE]   = res_col[j][0];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_col[l] = COL_W'(int'(cnt) * LANES + l);
        assign lane_in[l]  = src_col[lane_col[l]];

        sbox     u_fwd (.x(lane_in[l]), .y(lane_fwd[l]));
        sbox_inv u_bwd (.x(lane_in[l]), .y(lane_bwd[l]));

        assign lane_out[l] = mode ? lane_bwd[l] : lane_fwd[l];
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            // NOTE: these arrays are flops rather than RAM, so resetting them is legal; y must read 0.
            for (int j = 0; j < COLUMN_SIZE; j++) begin
                src_col[j] <= '0;
                res_col[j] <= '0;
            end
        end else if (abort) begin
            // The result register is deliberately kept; only control returns to IDLE.
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (in_valid && in_ready) begin
            state     <= BUSY;
            cnt       <= '0;
            mode      <= inv;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            for (int j = 0; j < COLUMN_SIZE; j++) begin
                src_col[j] <= x_col[j];
                res_col[j] <= '0;
            end
        end else begin
            case (state)
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        res_col[lane_col[l]] <= lane_out[l];
                    end
                    if (cnt == LAST) begin
                        state     <= DONE;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_beta_serial.sv
// Scoreboard bench for beta_serial: expected results queued on accept, compared when the DUT hands them off.

module tb_beta_serial;
    localparam int SIDE  = 64;
    localparam int C     = SIDE / 4;
    localparam int LANES = 4;
    localparam int ITERS = C / LANES;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            abort     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            inv       = 1'b0;
    logic            out_ready = 1'b0;
    logic [0:SIDE-1] x         = '0;
    logic            in_ready;
    logic            out_valid;
    logic            busy;
    logic [0:SIDE-1] y;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [0:SIDE-1] exp_y;
        int              acc;
    } txn_t;

    txn_t            sb[$];
    logic            prev_ov = 1'b0;
    logic [0:SIDE-1] last_y  = '0;

    logic [3:0] sf [16] = '{4'h1, 4'h2, 4'hC, 4'h5, 4'h7, 4'h8, 4'hA, 4'hF,
                            4'h4, 4'hD, 4'hB, 4'hE, 4'h9, 4'h6, 4'h0, 4'h3};

    beta_serial #(.SIDE_SIZE(SIDE), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inv       (inv),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Forward-only bit-sliced model; inverse expectations come from the known plaintext.
    function automatic logic [0:SIDE-1] fwd_model(input logic [0:SIDE-1] v);
        logic [0:SIDE-1] r;
        logic [3:0]      n;
        logic [3:0]      s;
        r = '0;
        for (int j = 0; j < C; j++) begin
            n = {v[j], v[j+C], v[j+2*C], v[j+3*C]};
            s = sf[n];
            r[j]     = s[3];
            r[j+C]   = s[2];
            r[j+2*C] = s[1];
            r[j+3*C] = s[0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        txn_t t;
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: out_valid rose with nothing pending, y=%h", y);
                end else if (cyc - sb[0].acc !== ITERS) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles, expected %0d", cyc - sb[0].acc, ITERS);
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                t = sb.pop_front();
                last_y = y;
                checks++;
                if (y !== t.exp_y) begin
                    errors++;
                    $display("FAIL result: y=%h expected %h", y, t.exp_y);
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // Called aligned just after a rising edge; returns aligned just after the accepting edge.
    task automatic send(input logic [0:SIDE-1] v, input logic m, input logic [0:SIDE-1] e);
        txn_t t;
        int   n;
        in_valid = 1'b1;
        x        = v;
        inv      = m;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b expected 1 within 100 cycles", in_ready);
        end else begin
            t.exp_y = e;
            t.acc   = cyc + 1;
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (y !== '0) begin errors++; $display("FAIL reset_y: got %h expected 0", y); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        logic [0:SIDE-1] e;
        e = 64'h0000_0000_0000_FFFF;
        out_ready = 1'b1;
        send('0, 1'b0, fwd_model('0));
        drain();
        checks++;
        if (last_y !== e) begin
            errors++;
            $display("FAIL zero_forward: y=%h expected %h", last_y, e);
        end
    endtask

    task automatic test_round_trip();
        logic [0:SIDE-1] v;
        logic [0:SIDE-1] f;
        out_ready = 1'b1;
        v = 64'h0123_4567_89AB_CDEF;
        f = fwd_model(v);
        send(v, 1'b0, f);
        send(f, 1'b1, v);
        for (int i = 0; i < 1000; i++) begin
            v = {$urandom, $urandom};
            f = fwd_model(v);
            send(v, 1'b0, f);
            send(f, 1'b1, v);
        end
        drain();
    endtask

    task automatic test_single_column();
        logic [0:SIDE-1] v;
        logic [0:SIDE-1] e;
        logic [3:0]      s;
        v    = '0;
        v[5] = 1'b1;
        e    = '0;
        for (int j = 0; j < C; j++) begin
            s = (j == 5) ? 4'h4 : 4'h1;
            e[j]     = s[3];
            e[j+C]   = s[2];
            e[j+2*C] = s[1];
            e[j+3*C] = s[0];
        end
        out_ready = 1'b1;
        send(v, 1'b0, e);
        drain();
        checks++;
        if (last_y !== e) begin
            errors++;
            $display("FAIL single_column: y=%h expected %h", last_y, e);
        end
    endtask

    task automatic test_backpressure();
        logic [0:SIDE-1] xa;
        logic [0:SIDE-1] xb;
        logic [0:SIDE-1] ea;
        txn_t            t;
        int              n;
        xa = 64'hDEAD_BEEF_0BAD_F00D;
        xb = 64'h1357_9BDF_0246_8ACE;
        ea = fwd_model(xa);
        out_ready = 1'b0;
        send(xa, 1'b0, ea);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid: got %b expected 1", out_valid); end
            if (y !== ea) begin errors++; $display("FAIL hold_y: got %h expected %h", y, ea); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = xb;
        inv       = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_accept: in_ready=%b expected 1", in_ready);
        end else begin
            t.exp_y = fwd_model(xb);
            t.acc   = cyc + 1;
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        logic [0:SIDE-1] v;
        out_ready = 1'b1;
        v = 64'hFEDC_BA98_7654_3210;
        send(v, 1'b0, fwd_model(v));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        if (y !== '0) begin errors++; $display("FAIL midreset_y: got %h expected 0", y); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = 64'hA5A5_5A5A_C3C3_3C3C;
        send(v, 1'b0, fwd_model(v));
        drain();
    endtask

    task automatic test_abort();
        logic [0:SIDE-1] v;
        txn_t            t;
        out_ready = 1'b1;
        v = 64'h0F0F_F0F0_1234_8765;
        send(v, 1'b0, fwd_model(v));
        @(posedge clk);
        #1;
        t        = sb.pop_front();
        abort    = 1'b1;
        in_valid = 1'b1;
        x        = 64'h7777_8888_9999_AAAA;
        inv      = 1'b0;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_out_valid: got %b expected 0 (expected y was %h)", out_valid, t.exp_y);
            end
        end
        @(posedge clk);
        #1;
        v = 64'h3141_5926_5358_9793;
        send(v, 1'b0, fwd_model(v));
        send(fwd_model(v), 1'b1, v);
        drain();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_round_trip();
        test_single_column();
        test_backpressure();
        test_reset_mid();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
